// File: rtl/rv32imc_ss_mem_arbiter_if.sv
// Purpose: bundles the fetch port, load/store port and shared bus port of the memory arbiter.
// Latency: none, this is wiring only.
// Backpressure: requesters hold req until ack/err, and the bus answers with mem_ack/mem_err.
interface rv32imc_ss_mem_arbiter_if;
    // Instruction-fetch port
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_data_o;
    // Load/store port
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_data_i;
    logic        data_ack;
    logic        data_err;
    logic [31:0] data_data_o;
    // Shared system bus
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_o;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_data_i;

    // Arbiter view: accepts hart requests and drives the bus
    modport slave (
        input  instr_req, instr_addr,
        output instr_ack, instr_err, instr_data_o,
        input  data_req, data_wr, data_addr, data_data_i,
        output data_ack, data_err, data_data_o,
        output mem_req, mem_wr, mem_addr, mem_data_o,
        input  mem_ack, mem_err, mem_data_i
    );

    // Environment view: hart ports plus bus responder
    modport master (
        output instr_req, instr_addr,
        input  instr_ack, instr_err, instr_data_o,
        output data_req, data_wr, data_addr, data_data_i,
        input  data_ack, data_err, data_data_o,
        input  mem_req, mem_wr, mem_addr, mem_data_o,
        output mem_ack, mem_err, mem_data_i
    );
endinterface

// File: rtl/rv32imc_ss_mem_arbiter.sv
// Purpose: shares one bus between fetch and load/store, using fixed priority with a fetch starvation guard and a bus timeout.
// Latency: mem_req rises 1 cycle after a request is sampled in IDLE, and ack/err follow mem_ack/mem_err in the same cycle.
// Backpressure: requesters hold req until ack/err; one IDLE cycle separates grants, and a hung bus is cut off after TIMEOUT_CYCLES.
module rv32imc_ss_mem_arbiter #(
    parameter logic        DATA_PRIO      = 1'b1,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                      clk,
    input logic                      reset,
    rv32imc_ss_mem_arbiter_if.slave  bus
);
    localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TLAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t        state, state_n;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          wr_q;

    logic any_req, both_req, starved, grant_d, nonprio_only;
    logic busy, timeout, done, rsp_ok, rsp_err;

    assign any_req  = bus.instr_req | bus.data_req;
    assign both_req = bus.instr_req & bus.data_req;
    assign starved  = (starve_cnt == SW'(STARVE_LIMIT));
    // On a tie the priority side wins unless the other side has waited out its quota
    assign grant_d  = both_req ? (DATA_PRIO ? ~starved : starved) : bus.data_req;
    assign nonprio_only = DATA_PRIO ? (bus.instr_req & ~bus.data_req)
                                    : (bus.data_req & ~bus.instr_req);

    assign busy    = (state != IDLE);
    // tmo_cnt is 0 in the first granted cycle, so the last allowed cycle is TLAST
    assign timeout = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TLAST));
    assign done    = busy & (bus.mem_ack | bus.mem_err | timeout);
    // Reset aborts silently, and an error outranks a simultaneous ack
    assign rsp_ok  = busy & bus.mem_ack & ~bus.mem_err & ~reset;
    assign rsp_err = busy & (bus.mem_err | (timeout & ~bus.mem_ack)) & ~reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state: grant from IDLE, then return to IDLE on completion, error or timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE:         if (any_req) state_n = grant_d ? GNT_D : GNT_I;
            GNT_I, GNT_D: if (done)    state_n = IDLE;
            default:      state_n = IDLE;
        endcase
    end

    // Starvation counter: counts priority wins while the other side waits
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (both_req)          starve_cnt <= starved ? '0 : starve_cnt + 1'b1;
            else if (nonprio_only) starve_cnt <= '0;
        end
    end

    // Timeout counter: runs only while a grant is outstanding
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) tmo_cnt <= '0;
        else if (!done)             tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Capture the winner's request at grant so later requester changes cannot leak onto the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (state == IDLE && any_req) begin
            addr_q  <= grant_d ? bus.data_addr : bus.instr_addr;
            wdata_q <= grant_d ? bus.data_data_i : 32'h0;
            wr_q    <= grant_d & bus.data_wr;
        end
    end

    assign bus.mem_req    = busy;
    assign bus.mem_wr     = (state == GNT_D) & wr_q;
    assign bus.mem_addr   = busy ? addr_q : 32'h0;
    assign bus.mem_data_o = (state == GNT_D) ? wdata_q : 32'h0;

    // A requester that dropped req mid-transaction gets no response
    assign bus.instr_ack    = (state == GNT_I) & bus.instr_req & rsp_ok;
    assign bus.instr_err    = (state == GNT_I) & bus.instr_req & rsp_err;
    assign bus.instr_data_o = bus.instr_ack ? bus.mem_data_i : 32'h0;
    assign bus.data_ack     = (state == GNT_D) & bus.data_req & rsp_ok;
    assign bus.data_err     = (state == GNT_D) & bus.data_req & rsp_err;
    assign bus.data_data_o  = bus.data_ack ? bus.mem_data_i : 32'h0;
endmodule

// File: tb/tb_rv32imc_ss_mem_arbiter.sv
// Purpose: self-checking bench for the fetch/data memory arbiter.
// Latency: outputs are sampled on the falling edge, and inputs change 1 time unit after the rising edge.
// Backpressure: the bench acts as both requesters and the bus responder.
module tb_rv32imc_ss_mem_arbiter;
    localparam int SL = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32imc_ss_mem_arbiter_if bus();

    rv32imc_ss_mem_arbiter #(
        .DATA_PRIO(1'b1), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ireq, dreq, dwr;
        logic [31:0] iaddr, daddr, wdata;
        logic        mack, merr;
        logic [31:0] rdata;
        logic        exp_d, exp_ack, exp_err;
    } vec_t;
    vec_t vt[6];
    vec_t v;

    // Reference model state: which side owns the bus, and for how many cycles
    int          m_own;   // 0 none, 1 fetch, 2 data
    int          m_el;
    int          m_st;
    logic [31:0] m_addr, m_wd;
    logic        m_wr;
    logic        i_done, d_done, e_ok, e_bad;
    logic        e_ia, e_ie, e_da, e_de;
    logic        exp_seq[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic mr, input logic mw,
                           input logic [31:0] ma, input logic [31:0] md,
                           input logic ia, input logic ie, input logic [31:0] id,
                           input logic da, input logic de, input logic [31:0] dd);
        chk({t, ".mem_req"},      32'(bus.mem_req),   32'(mr));
        chk({t, ".mem_wr"},       32'(bus.mem_wr),    32'(mw));
        chk({t, ".mem_addr"},     bus.mem_addr,       ma);
        chk({t, ".mem_data_o"},   bus.mem_data_o,     md);
        chk({t, ".instr_ack"},    32'(bus.instr_ack), 32'(ia));
        chk({t, ".instr_err"},    32'(bus.instr_err), 32'(ie));
        chk({t, ".instr_data_o"}, bus.instr_data_o,   id);
        chk({t, ".data_ack"},     32'(bus.data_ack),  32'(da));
        chk({t, ".data_err"},     32'(bus.data_err),  32'(de));
        chk({t, ".data_data_o"},  bus.data_data_o,    dd);
    endtask

    task automatic chk_zero(input string t);
        chk_all(t, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instr_req = 1'b0; bus.instr_addr = 32'h0;
        bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_addr = 32'h0; bus.data_data_i = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_data_i = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vt[0] = '{ireq:1'b1, dreq:1'b0, dwr:1'b0, iaddr:32'h1000_0000, daddr:32'h0, wdata:32'h0,
                  mack:1'b1, merr:1'b0, rdata:32'h0000_0013, exp_d:1'b0, exp_ack:1'b1, exp_err:1'b0};
        vt[1] = '{ireq:1'b0, dreq:1'b1, dwr:1'b0, iaddr:32'h0, daddr:32'h2000_0010, wdata:32'h0,
                  mack:1'b1, merr:1'b0, rdata:32'h1234_5678, exp_d:1'b1, exp_ack:1'b1, exp_err:1'b0};
        vt[2] = '{ireq:1'b0, dreq:1'b1, dwr:1'b1, iaddr:32'h0, daddr:32'h2000_0000, wdata:32'hDEAD_BEEF,
                  mack:1'b1, merr:1'b0, rdata:32'h0, exp_d:1'b1, exp_ack:1'b1, exp_err:1'b0};
        vt[3] = '{ireq:1'b1, dreq:1'b1, dwr:1'b1, iaddr:32'h1000_0008, daddr:32'h2000_0000, wdata:32'hDEAD_BEEF,
                  mack:1'b1, merr:1'b0, rdata:32'h0, exp_d:1'b1, exp_ack:1'b1, exp_err:1'b0};
        vt[4] = '{ireq:1'b1, dreq:1'b0, dwr:1'b0, iaddr:32'h1000_0020, daddr:32'h0, wdata:32'h0,
                  mack:1'b1, merr:1'b1, rdata:32'hFFFF_FFFF, exp_d:1'b0, exp_ack:1'b0, exp_err:1'b1};
        vt[5] = '{ireq:1'b0, dreq:1'b1, dwr:1'b0, iaddr:32'h0, daddr:32'h2000_0040, wdata:32'h0,
                  mack:1'b0, merr:1'b1, rdata:32'hA5A5_A5A5, exp_d:1'b1, exp_ack:1'b0, exp_err:1'b1};
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        do_reset();
        @(negedge clk); chk_zero("reset");
        tick();

        // Single transactions from the vector table; requester inputs are scrambled after the grant
        for (int r = 0; r < 6; r++) begin
            v = vt[r];
            do_reset();
            bus.instr_req = v.ireq; bus.instr_addr = v.iaddr;
            bus.data_req = v.dreq; bus.data_wr = v.dwr; bus.data_addr = v.daddr; bus.data_data_i = v.wdata;
            @(negedge clk); chk_zero($sformatf("vec%0d.idle", r));
            tick();
            bus.instr_addr = ~v.iaddr; bus.data_addr = ~v.daddr;
            bus.data_wr = ~v.dwr; bus.data_data_i = ~v.wdata;
            bus.mem_ack = v.mack; bus.mem_err = v.merr; bus.mem_data_i = v.rdata;
            @(negedge clk);
            chk_all($sformatf("vec%0d.gnt", r), 1'b1, v.exp_d & v.dwr,
                    v.exp_d ? v.daddr : v.iaddr, v.exp_d ? v.wdata : 32'h0,
                    ~v.exp_d & v.exp_ack, ~v.exp_d & v.exp_err, (~v.exp_d & v.exp_ack) ? v.rdata : 32'h0,
                    v.exp_d & v.exp_ack, v.exp_d & v.exp_err, (v.exp_d & v.exp_ack) ? v.rdata : 32'h0);
            tick();
            idle_inputs();
            @(negedge clk); chk_zero($sformatf("vec%0d.after", r));
            tick();
        end

        // Fetch acked on the third granted cycle
        do_reset();
        bus.instr_req = 1'b1; bus.instr_addr = 32'h1000_0004;
        tick();
        for (int c = 1; c <= 3; c++) begin
            bus.mem_ack = (c == 3); bus.mem_data_i = 32'h0000_0013;
            @(negedge clk);
            chk($sformatf("fetch.c%0d.mem_req", c), 32'(bus.mem_req), 32'd1);
            chk($sformatf("fetch.c%0d.mem_addr", c), bus.mem_addr, 32'h1000_0004);
            chk($sformatf("fetch.c%0d.instr_ack", c), 32'(bus.instr_ack), 32'(c == 3));
            tick();
        end
        idle_inputs();
        @(negedge clk);
        chk("fetch.c4.mem_req", 32'(bus.mem_req), 32'd0);
        chk("fetch.c4.instr_ack", 32'(bus.instr_ack), 32'd0);
        tick();

        // Simultaneous requests: store first, then fetch after one IDLE cycle
        do_reset();
        bus.instr_req = 1'b1; bus.instr_addr = 32'h1000_0008;
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h2000_0000; bus.data_data_i = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk_all("both.d", 1'b1, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        bus.data_req = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk); chk("both.idle.mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        bus.mem_ack = 1'b1; bus.mem_data_i = 32'h0010_0073;
        @(negedge clk);
        chk_all("both.i", 1'b1, 1'b0, 32'h1000_0008, 32'h0, 1'b1, 1'b0, 32'h0010_0073, 1'b0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        tick();

        // Starvation guard with both sides requesting continuously
        do_reset();
        bus.instr_req = 1'b1; bus.instr_addr = 32'h1000_0100;
        bus.data_req = 1'b1; bus.data_addr = 32'h2000_0100;
        tick();
        for (int k = 0; k < 6; k++) begin
            bus.mem_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("starve.g%0d.is_data", k), 32'(bus.mem_addr == 32'h2000_0100), 32'(exp_seq[k]));
            tick();
            bus.mem_ack = 1'b0;
            @(negedge clk); chk($sformatf("starve.g%0d.gap", k), 32'(bus.mem_req), 32'd0);
            tick();
        end
        idle_inputs();

        // Timeout on a hung load, then a late ack while IDLE
        do_reset();
        bus.data_req = 1'b1; bus.data_addr = 32'h3000_0000;
        tick();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            chk($sformatf("tmo.c%0d.mem_req", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("tmo.c%0d.data_err", k), 32'(bus.data_err), 32'(k == TO));
            tick();
        end
        bus.data_req = 1'b0;
        @(negedge clk);
        chk("tmo.after.mem_req", 32'(bus.mem_req), 32'd0);
        chk("tmo.after.data_err", 32'(bus.data_err), 32'd0);
        tick();
        bus.mem_ack = 1'b1;
        @(negedge clk); chk_zero("tmo.late_ack");
        tick();
        idle_inputs();

        // Error with ack on a fetch, then a normal load
        do_reset();
        bus.instr_req = 1'b1; bus.instr_addr = 32'h1000_0040;
        tick();
        bus.mem_ack = 1'b1; bus.mem_err = 1'b1; bus.mem_data_i = 32'h1111_2222;
        @(negedge clk);
        chk_all("berr.i", 1'b1, 1'b0, 32'h1000_0040, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        bus.data_req = 1'b1; bus.data_addr = 32'h2000_0080;
        tick();
        bus.mem_ack = 1'b1; bus.mem_data_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk_all("berr.d", 1'b1, 1'b0, 32'h2000_0080, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
        tick();
        idle_inputs();

        // Reset while a store is granted
        do_reset();
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h2000_00C0; bus.data_data_i = 32'h5555_AAAA;
        tick();
        @(negedge clk); chk("rstmid.mem_req", 32'(bus.mem_req), 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.r.data_ack", 32'(bus.data_ack), 32'd0);
        chk("rstmid.r.data_err", 32'(bus.data_err), 32'd0);
        tick();
        reset = 1'b0; bus.data_req = 1'b0; bus.mem_ack = 1'b1;
        @(negedge clk); chk_zero("rstmid.after");
        tick();
        idle_inputs();

        // Randomized traffic against the reference model
        do_reset();
        m_own = 0; m_el = 0; m_st = 0; m_addr = 0; m_wd = 0; m_wr = 0;
        i_done = 1'b0; d_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.instr_req) begin
                if (i_done) begin
                    if ($urandom_range(1, 0) == 1) bus.instr_addr = $urandom;
                    else bus.instr_req = 1'b0;
                end
            end else if ($urandom_range(3, 0) == 0) begin
                bus.instr_req = 1'b1; bus.instr_addr = $urandom;
            end
            if (bus.data_req) begin
                if (d_done) begin
                    if ($urandom_range(1, 0) == 1) begin
                        bus.data_addr = $urandom; bus.data_data_i = $urandom; bus.data_wr = 1'($urandom_range(1, 0));
                    end else bus.data_req = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                bus.data_req = 1'b1; bus.data_addr = $urandom; bus.data_data_i = $urandom;
                bus.data_wr = 1'($urandom_range(1, 0));
            end
            bus.mem_ack = ($urandom_range(4, 0) == 0);
            bus.mem_err = ($urandom_range(9, 0) == 0);
            bus.mem_data_i = $urandom;
            @(negedge clk);
            e_ok  = (m_own != 0) && bus.mem_ack && !bus.mem_err;
            e_bad = (m_own != 0) && (bus.mem_err || (m_el == TO && !bus.mem_ack));
            e_ia  = (m_own == 1) && bus.instr_req && e_ok;
            e_ie  = (m_own == 1) && bus.instr_req && e_bad;
            e_da  = (m_own == 2) && bus.data_req && e_ok;
            e_de  = (m_own == 2) && bus.data_req && e_bad;
            chk_all("rnd", m_own != 0, (m_own == 2) && m_wr, (m_own != 0) ? m_addr : 32'h0,
                    (m_own == 2) ? m_wd : 32'h0, e_ia, e_ie, e_ia ? bus.mem_data_i : 32'h0,
                    e_da, e_de, e_da ? bus.mem_data_i : 32'h0);
            i_done = e_ia || e_ie;
            d_done = e_da || e_de;
            if (m_own == 0) begin
                if (bus.instr_req && bus.data_req) begin
                    if (m_st == SL) begin m_own = 1; m_st = 0; end
                    else begin m_own = 2; m_st++; end
                end else if (bus.instr_req) begin
                    m_own = 1; m_st = 0;
                end else if (bus.data_req) begin
                    m_own = 2;
                end
                if (m_own == 1) begin
                    m_addr = bus.instr_addr; m_wr = 1'b0; m_wd = 32'h0;
                end else if (m_own == 2) begin
                    m_addr = bus.data_addr; m_wr = bus.data_wr; m_wd = bus.data_data_i;
                end
                m_el = 1;
            end else if (e_ok || e_bad) begin
                m_own = 0;
            end else begin
                m_el++;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
